// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronizes and debounces four game buttons plus a start button,
// producing stable levels, single-press pulses and a multiple-press flag.
module condicionador_botoes #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes_raw,
    input  logic       iniciar_raw,
    output logic [3:0] botoes,
    output logic [3:0] botoes_pulso,
    output logic       iniciar,
    output logic       multiplo,
    output logic [4:0] db_estavel
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0] raw_all;
    logic [4:0] s1_reg;
    logic [4:0] s2_reg;
    logic [4:0] stable_reg;
    logic [4:0] stable_next;
    logic [4:0] rise;
    logic [3:0] press_ok;
    logic [3:0] botoes_pulso_reg;
    logic       iniciar_reg;
    logic       multiplo_reg;

    // Bit 4 is the start button, bits 3:0 the game buttons.
    assign raw_all = {iniciar_raw, botoes_raw};
    assign rise    = stable_next & ~stable_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic             differs;
            logic             qualified;

            assign differs          = s2_reg[gi] ^ stable_reg[gi];
            assign qualified        = differs && (cnt_reg == CNT_MAX);
            assign stable_next[gi]  = qualified ? s2_reg[gi] : stable_reg[gi];

            // Any cycle agreeing with the stable level restarts qualification.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else if (!differs || qualified) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end

        // A button press only counts when it is the sole button held after this edge.
        for (gi = 0; gi < 4; gi++) begin : g_press
            localparam logic [3:0] OTHERS = ~(4'(1) << gi);
            assign press_ok[gi] = rise[gi] && ((stable_next[3:0] & OTHERS) == 4'b0000);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_reg           <= '0;
            s2_reg           <= '0;
            stable_reg       <= '0;
            botoes_pulso_reg <= '0;
            iniciar_reg      <= 1'b0;
            multiplo_reg     <= 1'b0;
        end else begin
            s1_reg           <= raw_all;
            s2_reg           <= s1_reg;
            stable_reg       <= stable_next;
            botoes_pulso_reg <= press_ok;
            iniciar_reg      <= rise[4];
            multiplo_reg     <= ($countones(stable_next[3:0]) > 1);
        end
    end

    assign botoes       = stable_reg[3:0];
    assign botoes_pulso = botoes_pulso_reg;
    assign iniciar      = iniciar_reg;
    assign multiplo     = multiplo_reg;
    assign db_estavel   = stable_reg;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with DEBOUNCE_CYCLES=4 (6-edge press latency).
module tb_condicionador_botoes;

    localparam int DB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] botoes_raw = 4'b0000;
    logic       iniciar_raw = 1'b0;
    logic [3:0] botoes;
    logic [3:0] botoes_pulso;
    logic       iniciar;
    logic       multiplo;
    logic [4:0] db_estavel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    condicionador_botoes #(.DEBOUNCE_CYCLES(DB)) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes_raw   (botoes_raw),
        .iniciar_raw  (iniciar_raw),
        .botoes       (botoes),
        .botoes_pulso (botoes_pulso),
        .iniciar      (iniciar),
        .multiplo     (multiplo),
        .db_estavel   (db_estavel)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        botoes_raw  = 4'b0000;
        iniciar_raw = 1'b0;
        reset       = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        logic [14:0] exp_v;
        #2;
        reset       = 1'b0;
        botoes_raw  = 4'b1111;
        iniciar_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            obs = {botoes, botoes_pulso, iniciar, multiplo, db_estavel};
            n_cmp++;
            if (obs !== 15'd0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d outputs=%h required=0", i, obs);
            end
            step();
        end
        reset = 1'b1;
        // All inputs held at release: start pulse and multiplo, no button pulse.
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_v = (i < 6)  ? 15'd0 :
                    (i == 6) ? {4'b1111, 4'b0000, 1'b1, 1'b1, 5'h1F} :
                               {4'b1111, 4'b0000, 1'b0, 1'b1, 5'h1F};
            obs = {botoes, botoes_pulso, iniciar, multiplo, db_estavel};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_release_all edge=%0d outputs=%h required=%h", i, obs, exp_v);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_b;
        logic [3:0] exp_p;
        apply_reset();
        botoes_raw = 4'b0100;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_b = (i >= 6) ? 4'b0100 : 4'b0000;
            exp_p = (i == 6) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (botoes !== exp_b || botoes_pulso !== exp_p || db_estavel !== {1'b0, exp_b}) begin
                n_bad++;
                $display("FAIL clean_press edge=%0d botoes=%b pulso=%b db=%b required %b/%b", i, botoes, botoes_pulso, db_estavel, exp_b, exp_p);
            end
        end
        $display("test_clean_press done");
    endtask

    task automatic test_release_repress();
        logic [3:0] exp_b;
        logic [3:0] exp_p;
        botoes_raw = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            step();
            exp_b = (i >= 6) ? 4'b0000 : 4'b0100;
            n_cmp++;
            if (botoes !== exp_b || botoes_pulso !== 4'b0000) begin
                n_bad++;
                $display("FAIL release edge=%0d botoes=%b pulso=%b required %b/0000", i, botoes, botoes_pulso, exp_b);
            end
        end
        botoes_raw = 4'b0100;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_b = (i >= 6) ? 4'b0100 : 4'b0000;
            exp_p = (i == 6) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (botoes !== exp_b || botoes_pulso !== exp_p) begin
                n_bad++;
                $display("FAIL repress edge=%0d botoes=%b pulso=%b required %b/%b", i, botoes, botoes_pulso, exp_b, exp_p);
            end
        end
        $display("test_release_repress done");
    endtask

    task automatic test_bounce();
        logic [3:0] exp_b;
        logic [3:0] exp_p;
        logic [3:0] pattern;
        apply_reset();
        pattern = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            botoes_raw = {2'b00, pattern[i], 1'b0};
            step();
            n_cmp++;
            if (botoes !== 4'b0000 || botoes_pulso !== 4'b0000) begin
                n_bad++;
                $display("FAIL bounce_toggle cyc=%0d botoes=%b pulso=%b required 0000/0000", i, botoes, botoes_pulso);
            end
        end
        botoes_raw = 4'b0010;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_b = (i >= 6) ? 4'b0010 : 4'b0000;
            exp_p = (i == 6) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (botoes !== exp_b || botoes_pulso !== exp_p) begin
                n_bad++;
                $display("FAIL bounce_settle edge=%0d botoes=%b pulso=%b required %b/%b", i, botoes, botoes_pulso, exp_b, exp_p);
            end
        end
        $display("test_bounce done");
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_b;
        apply_reset();
        botoes_raw = 4'b1001;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_b = (i >= 6) ? 4'b1001 : 4'b0000;
            n_cmp++;
            if (botoes !== exp_b || botoes_pulso !== 4'b0000 || multiplo !== (i >= 6)) begin
                n_bad++;
                $display("FAIL simultaneous edge=%0d botoes=%b pulso=%b multiplo=%b required %b/0000/%0d", i, botoes, botoes_pulso, multiplo, exp_b, (i >= 6));
            end
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_rise_while_held();
        logic [3:0] exp_b;
        apply_reset();
        botoes_raw = 4'b0001;
        for (int i = 0; i < 8; i++) step();
        botoes_raw = 4'b0101;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_b = (i >= 6) ? 4'b0101 : 4'b0001;
            n_cmp++;
            if (botoes !== exp_b || botoes_pulso !== 4'b0000 || multiplo !== (i >= 6)) begin
                n_bad++;
                $display("FAIL rise_while_held edge=%0d botoes=%b pulso=%b multiplo=%b required %b/0000/%0d", i, botoes, botoes_pulso, multiplo, exp_b, (i >= 6));
            end
        end
        $display("test_rise_while_held done");
    endtask

    task automatic test_start_held();
        int pulses;
        apply_reset();
        botoes_raw = 4'b0001;
        for (int i = 0; i < 8; i++) step();
        iniciar_raw = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (iniciar === 1'b1) pulses++;
            n_cmp++;
            if (iniciar !== (i == 6) || db_estavel !== {(i >= 6) ? 1'b1 : 1'b0, 4'b0001} || botoes_pulso !== 4'b0000) begin
                n_bad++;
                $display("FAIL start_held edge=%0d iniciar=%b db=%b pulso=%b required %0d/%b/0000", i, iniciar, db_estavel, botoes_pulso, (i == 6), {(i >= 6) ? 1'b1 : 1'b0, 4'b0001});
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL start_pulse_count count=%0d required=1", pulses);
        end
        iniciar_raw = 1'b0;
        $display("test_start_held done");
    endtask

    task automatic test_reset_mid();
        logic [14:0] obs;
        logic [3:0]  exp_b;
        logic [3:0]  exp_p;
        apply_reset();
        botoes_raw = 4'b0010;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = {botoes, botoes_pulso, iniciar, multiplo, db_estavel};
            n_cmp++;
            if (obs !== 15'd0) begin
                n_bad++;
                $display("FAIL reset_mid_hold cyc=%0d outputs=%h required=0", i, obs);
            end
            step();
        end
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_b = (i >= 6) ? 4'b0010 : 4'b0000;
            exp_p = (i == 6) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (botoes !== exp_b || botoes_pulso !== exp_p) begin
                n_bad++;
                $display("FAIL reset_mid_restart edge=%0d botoes=%b pulso=%b required %b/%b", i, botoes, botoes_pulso, exp_b, exp_p);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_repress();
        test_bounce();
        test_simultaneous();
        test_rise_while_held();
        test_start_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
